// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles.
// Produces a WIDTH-bit sum, carry-out and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             OVF
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic sum, cry, last;
  logic accept, run, done_idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    p_d     = p_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    sum  = a_q[0] ^ b_q[0] ^ c_q;
    cry  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    last = (cnt_q == LAST);

    accept    = START && (state_q != ST_RUN);
    run       = (state_q == ST_RUN);
    done_idle = (state_q == ST_DONE) && !START;

    unique case (1'b1)
      accept: begin
        state_d = ST_RUN;
        cnt_d   = '0;
        a_d     = A;
        b_d     = SUB ? ~B : B;
        c_d     = SUB | Ci;
      end
      run: begin
        p_d            = p_q >> 1;
        p_d[WIDTH-1]   = sum;
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        c_d            = cry;
        cnt_d          = cnt_q + CW'(1);
        if (last) begin
          // c_q is the carry into the MSB on this final bit
          state_d = ST_DONE;
          cnt_d   = '0;
          s_d     = p_d;
          co_d    = cry;
          ovf_d   = c_q ^ cry;
        end
      end
      done_idle: state_d = ST_IDLE;
      default: begin
        if (state_q != ST_IDLE && state_q != ST_DONE)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      p_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      p_q     <= p_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_DONE);
  assign S    = s_q;
  assign Co   = co_q;
  assign OVF  = ovf_q;

endmodule
